// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Captured addresses are held at full requester width; the memory only sees the low bits.
    localparam int REQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                  we;
        logic [2:0]            funct3;
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic                  err;
        req_id_e               id;
    } req_t;

endpackage

// File: rtl/dmem_access_check.sv
// rtl/dmem_access_check.sv - combinational funct3/alignment/range validator
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

    logic            f3_ok;
    logic            align_ok;
    logic [1:0]      size_m1;
    logic [ADDR_W:0] last_byte;

    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        size_m1  = 2'd0;
        case (funct3)
            F3_B:  f3_ok = 1'b1;
            F3_BU: f3_ok = !we;
            F3_H: begin
                f3_ok    = 1'b1;
                size_m1  = 2'd1;
                align_ok = !addr[0];
            end
            F3_HU: begin
                f3_ok    = !we;
                size_m1  = 2'd1;
                align_ok = !addr[0];
            end
            F3_W: begin
                f3_ok    = 1'b1;
                size_m1  = 2'd3;
                align_ok = (addr[1:0] == 2'b00);
            end
            default: f3_ok = 1'b0;
        endcase
        // One extra bit keeps an access near the top of the address space from wrapping into range.
        last_byte = {1'b0, addr} + {{(ADDR_W-1){1'b0}}, size_m1};
        err       = !f3_ok || !align_ok || (last_byte >= DEPTH_L);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32,
    parameter int RR_MODE     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           c_req,
    input  logic                           c_we,
    input  logic [2:0]                     c_funct3,
    input  logic [ADDR_W-1:0]              c_addr,
    input  logic [31:0]                    c_wdata,
    output logic                           c_gnt,
    output logic                           c_rvalid,
    output logic [31:0]                    c_rdata,
    output logic                           c_err,
    input  logic                           d_req,
    input  logic                           d_we,
    input  logic [2:0]                     d_funct3,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [31:0]                    d_wdata,
    output logic                           d_gnt,
    output logic                           d_rvalid,
    output logic [31:0]                    d_rdata,
    output logic                           d_err,
    output logic                           m_en,
    output logic                           m_we,
    output logic [2:0]                     m_funct3,
    output logic [$clog2(DEPTH_BYTES)-1:0] m_addr,
    output logic [31:0]                    m_wdata,
    input  logic [31:0]                    m_rdata
);

    localparam int MEM_AW = $clog2(DEPTH_BYTES);

    state_e            state_q, state_d;
    req_id_e           last_grant_q, last_grant_d;
    req_t              req_q, req_d;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;

    logic              any_req;
    req_id_e           win_id;
    logic              win_we;
    logic [2:0]        win_f3;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic              win_err;
    logic              gnt;
    logic              resp;
    logic [31:0]       rsp_rdata;
    logic              unused_addr_bits;

    always_comb begin
        any_req = c_req || d_req;
        if (c_req && d_req) begin
            win_id = ((RR_MODE != 0) && (last_grant_q == REQ_CORE)) ? REQ_DBG : REQ_CORE;
        end else if (d_req) begin
            win_id = REQ_DBG;
        end else begin
            win_id = REQ_CORE;
        end
        win_we    = (win_id == REQ_DBG) ? d_we     : c_we;
        win_f3    = (win_id == REQ_DBG) ? d_funct3 : c_funct3;
        win_addr  = (win_id == REQ_DBG) ? d_addr   : c_addr;
        win_wdata = (win_id == REQ_DBG) ? d_wdata  : c_wdata;
    end

    dmem_access_check #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_check (
        .we    (win_we),
        .funct3(win_f3),
        .addr  (win_addr),
        .err   (win_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_DBG;
            req_q        <= '0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_ACCESS;
                    last_grant_d = win_id;
                    req_d        = '{we: win_we, funct3: win_f3, addr: REQ_ADDR_W'(win_addr),
                                     wdata: win_wdata, err: win_err, id: win_id};
                    // A failed check keeps the strobe low so memory is never touched.
                    m_en_d       = !win_err;
                    m_we_d       = !win_err && win_we;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt       = rst_n && (state_q == ST_IDLE) && any_req;
        c_gnt     = gnt && (win_id == REQ_CORE);
        d_gnt     = gnt && (win_id == REQ_DBG);
        resp      = (state_q == ST_RESP);
        rsp_rdata = (!req_q.err && !req_q.we) ? m_rdata : 32'h0;
        c_rvalid  = resp && (req_q.id == REQ_CORE);
        d_rvalid  = resp && (req_q.id == REQ_DBG);
        c_err     = c_rvalid && req_q.err;
        d_err     = d_rvalid && req_q.err;
        c_rdata   = c_rvalid ? rsp_rdata : 32'h0;
        d_rdata   = d_rvalid ? rsp_rdata : 32'h0;
    end

    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_funct3 = req_q.funct3;
    assign m_addr   = req_q.addr[MEM_AW-1:0];
    assign m_wdata  = req_q.wdata;

    assign unused_addr_bits = ^req_q.addr[REQ_ADDR_W-1:MEM_AW];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [2:0]  c_funct3, d_funct3;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        m_en, m_we;
    logic [2:0]  m_funct3;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    logic        p_c_gnt, p_c_rvalid, p_c_err, p_d_gnt, p_d_rvalid, p_d_err;
    logic [31:0] p_c_rdata, p_d_rdata;
    logic        p_m_en, p_m_we;
    logic [2:0]  p_m_funct3;
    logic [6:0]  p_m_addr;
    logic [31:0] p_m_wdata;
    logic [31:0] p_m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:127];
    logic [7:0] rb0, rb1, rb2, rb3;

    dmem_arbiter #(.DEPTH_BYTES(128), .ADDR_W(32), .RR_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_funct3(m_funct3), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    dmem_arbiter #(.DEPTH_BYTES(128), .ADDR_W(32), .RR_MODE(0)) dut_prio (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(p_c_gnt), .c_rvalid(p_c_rvalid), .c_rdata(p_c_rdata), .c_err(p_c_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata), .d_err(p_d_err),
        .m_en(p_m_en), .m_we(p_m_we), .m_funct3(p_m_funct3), .m_addr(p_m_addr), .m_wdata(p_m_wdata),
        .m_rdata(p_m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign p_m_rdata = 32'h0;
    assign rb0 = mem[m_addr];
    assign rb1 = mem[m_addr + 7'd1];
    assign rb2 = mem[m_addr + 7'd2];
    assign rb3 = mem[m_addr + 7'd3];

    // Byte-addressed memory model: write/read on the edge after m_en, loads extended here.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr] = m_wdata[7:0];
                if (m_funct3[1:0] != 2'b00) mem[m_addr + 7'd1] = m_wdata[15:8];
                if (m_funct3[1:0] == 2'b10) begin
                    mem[m_addr + 7'd2] = m_wdata[23:16];
                    mem[m_addr + 7'd3] = m_wdata[31:24];
                end
            end else begin
                case (m_funct3)
                    3'b000:  m_rdata <= {{24{rb0[7]}}, rb0};
                    3'b001:  m_rdata <= {{16{rb1[7]}}, rb1, rb0};
                    3'b100:  m_rdata <= {24'h0, rb0};
                    3'b101:  m_rdata <= {16'h0, rb1, rb0};
                    default: m_rdata <= {rb3, rb2, rb1, rb0};
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string name, input logic dbg, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err);
        if (dbg) begin
            d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd;
        end
        #1;
        chk({name, " gnt"}, 32'(dbg ? d_gnt : c_gnt), 32'd1);
        chk({name, " other_gnt"}, 32'(dbg ? c_gnt : d_gnt), 32'd0);
        @(negedge clk);
        c_req = 1'b0;
        d_req = 1'b0;
        chk({name, " m_en"}, 32'(m_en), 32'(!exp_err));
        chk({name, " m_we"}, 32'(m_we), 32'(we && !exp_err));
        if (!exp_err) chk({name, " m_addr"}, 32'(m_addr), {25'h0, addr[6:0]});
        @(negedge clk);
        chk({name, " rvalid"}, 32'(dbg ? d_rvalid : c_rvalid), 32'd1);
        chk({name, " other_rvalid"}, 32'(dbg ? c_rvalid : d_rvalid), 32'd0);
        chk({name, " rdata"}, dbg ? d_rdata : c_rdata, exp_rdata);
        chk({name, " err"}, 32'(dbg ? d_err : c_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        m_rdata = 32'h0;

        rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h10; c_wdata = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0;  d_wdata = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst c_gnt", 32'(c_gnt), 32'd0);
        chk("rst d_gnt", 32'(d_gnt), 32'd0);
        chk("rst m_en", 32'(m_en), 32'd0);
        chk("rst m_we", 32'(m_we), 32'd0);
        chk("rst m_addr", 32'(m_addr), 32'd0);
        chk("rst c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst c_rdata", c_rdata, 32'd0);
        chk("rst c_err", 32'(c_err), 32'd0);
        chk("rst prio c_gnt", 32'(p_c_gnt), 32'd0);

        // Both requesting from reset release: RR grants core, debug, core; priority grants core only.
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("rr c_gnt cyc%0d", i), 32'(c_gnt), 32'((i % 3 == 0) && (i != 3)));
            chk($sformatf("rr d_gnt cyc%0d", i), 32'(d_gnt), 32'(i == 3));
            chk($sformatf("prio c_gnt cyc%0d", i), 32'(p_c_gnt), 32'(i % 3 == 0));
            chk($sformatf("prio d_gnt cyc%0d", i), 32'(p_d_gnt), 32'd0);
            @(negedge clk);
        end
        c_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);

        txn("core_lw_10",    1'b0, 1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
        txn("core_sh_11",    1'b0, 1'b1, 3'b001, 32'h11,       32'h0000AAAA, 32'h0,        1'b1);
        txn("core_lw_10b",   1'b0, 1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
        txn("dbg_sw_7c",     1'b1, 1'b1, 3'b010, 32'h7C,       32'h12345678, 32'h0,        1'b0);
        txn("core_lw_7c",    1'b0, 1'b0, 3'b010, 32'h7C,       32'h0,        32'h12345678, 1'b0);
        txn("dbg_sw_7e",     1'b1, 1'b1, 3'b010, 32'h7E,       32'hCAFEF00D, 32'h0,        1'b1);
        txn("dbg_sh_7f",     1'b1, 1'b1, 3'b001, 32'h7F,       32'h0000BEEF, 32'h0,        1'b1);
        txn("core_f3_011",   1'b0, 1'b0, 3'b011, 32'h0,        32'h0,        32'h0,        1'b1);
        txn("core_lb_13",    1'b0, 1'b0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 1'b0);
        txn("core_lbu_13",   1'b0, 1'b0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 1'b0);
        txn("core_lh_12",    1'b0, 1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 1'b0);
        txn("core_lhu_7e",   1'b0, 1'b0, 3'b101, 32'h7E,       32'h0,        32'h00001234, 1'b0);
        txn("core_lw_80",    1'b0, 1'b0, 3'b010, 32'h80,       32'h0,        32'h0,        1'b1);
        txn("core_lw_wrap",  1'b0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1);
        txn("core_st_f3bu",  1'b0, 1'b1, 3'b100, 32'h0,        32'h55,       32'h0,        1'b1);
        txn("core_sb_7f",    1'b0, 1'b1, 3'b000, 32'h7F,       32'hFFFFFF99, 32'h0,        1'b0);
        txn("core_lw_7c_b",  1'b0, 1'b0, 3'b010, 32'h7C,       32'h0,        32'h99345678, 1'b0);

        // Reset while a core load is in ACCESS: strobe drops at once and no response follows.
        c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h10;
        #1;
        chk("rstacc gnt", 32'(c_gnt), 32'd1);
        @(negedge clk);
        c_req = 1'b0;
        chk("rstacc m_en before", 32'(m_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstacc m_en after", 32'(m_en), 32'd0);
        chk("rstacc m_funct3", 32'(m_funct3), 32'd0);
        @(negedge clk);
        chk("rstacc c_rvalid in rst", 32'(c_rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstacc c_rvalid after", 32'(c_rvalid), 32'd0);
        chk("rstacc d_rvalid after", 32'(d_rvalid), 32'd0);
        c_req = 1'b1; d_req = 1'b1;
        #1;
        chk("rstacc core first", 32'(c_gnt), 32'd1);
        chk("rstacc dbg waits", 32'(d_gnt), 32'd0);
        @(negedge clk);
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port, byte-addressed data memory between two requesters: the core load/store path (requester 0) and the debug/program-loader port (requester 1).
- Serialises accesses with a req/gnt/rvalid handshake, then issues one registered memory access per transaction.
- Screens out misaligned, out-of-range and illegal-funct3 accesses with an error response. These accesses never reach memory.
- Sits between the execute/memory pipeline boundary and the data memory array. The core stalls on !c_gnt.

Parameters:
DEPTH_BYTES, 128, data memory size in bytes; must be a power of two.
ADDR_W, 32, requester address width.
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority with core first.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
c_req  in  1  core request valid; held until c_gnt
c_we  in  1  core write (store) when 1, read (load) when 0
c_funct3  in  3  RISC-V load/store funct3
c_addr  in  ADDR_W  core byte address
c_wdata  in  32  core store data, LSB-aligned
c_gnt  out  1  core request accepted this cycle (combinational)
c_rvalid  out  1  core response pulse
c_rdata  out  32  core load data, valid with c_rvalid
c_err  out  1  core access error, valid with c_rvalid
d_req, d_we, d_funct3, d_addr, d_wdata  in  1/1/3/ADDR_W/32  debug requester, same semantics as core
d_gnt, d_rvalid, d_rdata, d_err  out  1/1/32/1  debug responses, same semantics as core
m_en  out  1  memory access strobe (registered)
m_we  out  1  memory write enable (registered)
m_funct3  out  3  width/sign to memory (registered)
m_addr  out  $clog2(DEPTH_BYTES)  memory byte address (registered)
m_wdata  out  32  memory write data (registered)
m_rdata  in  32  memory read data, valid one cycle after m_en

Behaviour:
- Reset: while rst_n is low, asynchronously force the following. Nothing pending survives reset, including a transaction already in ACCESS or RESP; that transaction receives no response.
  - state = IDLE and last_grant = 1, so the core wins the first tie.
  - All m_* outputs, *_gnt, *_rvalid and *_err are 0.
  - c_rdata and d_rdata are 0.
- State IDLE:
  - If any *_req is high, select a winner and assert its *_gnt combinationally in the same cycle.
  - Capture the winner's we, funct3, addr and wdata, plus the check result, into the request register, then go to ACCESS.
  - With no request, stay in IDLE.
- Winner selection:
  - RR_MODE=1: if both request, the requester not granted last wins; a single requester always wins.
  - RR_MODE=0: core always wins.
  - last_grant updates on every grant.
- Access check (combinational, on the winner):
  - funct3 must be one of 000, 001, 010, 100, 101 for loads, or 000, 001, 010 for stores.
  - Halfword accesses require addr[0]=0; word accesses require addr[1:0]=0.
  - The address must satisfy addr + size - 1 < DEPTH_BYTES, with no wrap-around.
  - Any failure sets the captured err flag.
- State ACCESS (one cycle):
  - If err is clear: m_en=1 and m_we=captured we; m_addr is the low address bits; funct3 and wdata pass through.
  - If err is set: m_en=0 and m_we=0, so memory is untouched.
  - Go to RESP.
- State RESP (one cycle):
  - Pulse the granted requester's *_rvalid.
  - *_rdata = m_rdata for an error-free load; otherwise 0.
  - *_err = captured err.
  - Stores also get rvalid as a write acknowledge.
  - Return to IDLE.
- Latency and throughput:
  - gnt at cycle T, m_en at T+1, rvalid at T+2.
  - At most one transaction per 3 cycles; no grant is issued in ACCESS or RESP.
- Rules:
  - A requester must keep req and its payload stable until gnt. Request changes during ACCESS or RESP are ignored.
  - The non-granted requester waits; it is never starved under RR_MODE=1.
  - rvalid and rdata/err of the non-granted requester stay 0.

Decomposition:
- Package dmem_pkg contains:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (ST_IDLE, ST_ACCESS, ST_RESP).
  - Requester-id enum (REQ_CORE, REQ_DBG).
  - Request struct holding we, funct3, addr, wdata, err and id.
- Sub-module dmem_access_check: purely combinational alignment/range/funct3 validator, parameterised by DEPTH_BYTES. Reused later for instruction-side checks.

Test Plan:
- Core LW, c_addr=0x10, memory word 0xDEADBEEF, d_req=0 -> c_gnt at T; m_en=1 and m_addr=0x10 at T+1; c_rvalid=1, c_rdata=0xDEADBEEF, c_err=0 at T+2.
- c_req and d_req both high at reset release, RR_MODE=1 -> grants go core, debug, core on successive IDLE cycles. With RR_MODE=0, only core is granted while c_req stays high.
- Core SH, c_addr=0x11 -> m_en stays 0 for the whole transaction; c_rvalid=1 and c_err=1 at T+2; memory contents unchanged.
- Debug SW, d_addr=0x7C, d_wdata=0x12345678 -> m_we=1 at T+1 and d_rvalid=1 with d_err=0 at T+2. A following core LW at 0x7C returns 0x12345678. A debug SW at 0x7E instead gives d_err=1 (misaligned); an SH at 0x7F gives d_err=1 (misaligned).
- Core load with funct3=011 at addr 0x0 -> c_err=1 and c_rdata=0 at T+2.
- Drop rst_n during ACCESS -> m_en falls to 0 immediately with no rvalid afterward. After release, the next request is granted from IDLE with core priority.
